// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_pkg
//  Description : Shared types and default constants for button_conditioner:
//                button FSM state encoding and debounce/auto-repeat defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // Button FSM state encoding
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_t;

    // Default number of consecutive stable samples needed to accept a change
    localparam int DEB_CYCLES_DEFAULT    = 4;

    // Default auto-repeat interval in clocks
    localparam int REPEAT_CYCLES_DEFAULT = 16;

    // Width of the auto-repeat counter (covers intervals up to 65535)
    localparam int REPEAT_CNT_W          = 16;

endpackage
`default_nettype wire

// File: rtl/button_conditioner_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Two-flop synchronizer followed by a saturating debounce
//                counter. The stable level changes only after DEB_CYCLES
//                consecutive synchronized samples disagree with it; any
//                agreeing sample restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce
    import cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int             CW         = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // Synchronize the raw input, then count disagreeing samples until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt >= C_CNT_LAST) begin
                // Final disagreeing sample: accept the new level; the count
                // never exceeds C_CNT_LAST so it cannot wrap.
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Conditions a bouncing push-button and mode switch for a pulse
//                controller. The button yields a one-cycle init strobe on each
//                debounced press; the switch yields a debounced per level.
//                Optional macro INIT_AUTOREPEAT_EN adds an init strobe every
//                REPEAT_CYCLES clocks while the button stays held.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import cond_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic sw_raw,
    output logic init,
    output logic per
);

    // Elaboration-time guard on the legal parameter ranges
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
        $error("button_conditioner: parameter out of legal range");
    end

    logic       w_btn_stable;
    logic       w_sw_stable;
    btn_state_t r_state;
    btn_state_t w_state_next;
    logic       w_init_next;
    logic       w_rep_hit;
    logic       r_init;
    logic       r_per;

    debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_raw),
        .stable (w_btn_stable)
    );

    debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_sw (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sw_raw),
        .stable (w_sw_stable)
    );

`ifdef INIT_AUTOREPEAT_EN
    localparam logic [REPEAT_CNT_W-1:0] C_REP_LAST = REPEAT_CNT_W'(REPEAT_CYCLES - 1);

    logic [REPEAT_CNT_W-1:0] r_rep_cnt;

    // Repeat interval counter: held at zero in IDLE so it starts fresh in HELD
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == IDLE) begin
            r_rep_cnt <= '0;
        end else if (w_rep_hit) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + REPEAT_CNT_W'(1);
        end
    end

    assign w_rep_hit = (r_state == HELD) && (r_rep_cnt == C_REP_LAST);
`else
    assign w_rep_hit = 1'b0;
`endif

    // Next-state and strobe decode; the strobe is registered with the state
    always_comb begin
        w_state_next = r_state;
        w_init_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_stable) begin
                    w_state_next = HELD;
                    w_init_next  = 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_stable) begin
                    w_state_next = IDLE;
                end else if (w_rep_hit) begin
                    w_init_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, init strobe and registered mode level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_init  <= 1'b0;
            r_per   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_init  <= w_init_next;
            r_per   <= w_sw_stable;
        end
    end

    assign init = r_init;
    assign per  = r_per;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed bench for button_conditioner. Expected init edges
//                and per change edges are queued when stimulus is applied and
//                compared every cycle. Honors INIT_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int REP = 16;
    localparam int LAT = DEB + 2;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic sw_raw;
    logic init;
    logic per;

    int   checks;
    int   errors;
    int   edge_n;
    logic exp_init;
    logic exp_per;
    int   iq[$];
    int   pq[$];

    button_conditioner #(
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .sw_raw  (sw_raw),
        .init    (init),
        .per     (per)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and compare both outputs with the scoreboard
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            exp_per = 1'b0;
            iq.delete();
            pq.delete();
        end
        exp_init = 1'b0;
        if (iq.size() > 0 && iq[0] == edge_n) begin
            exp_init = 1'b1;
            void'(iq.pop_front());
        end
        if (pq.size() > 0 && pq[0] == edge_n) begin
            exp_per = ~exp_per;
            void'(pq.pop_front());
        end
        #1;
        checks++;
        assert (init === exp_init) else begin
            errors++;
            $error("FAIL init edge=%0d observed=%b expected=%b", edge_n, init, exp_init);
        end
        checks++;
        assert (per === exp_per) else begin
            errors++;
            $error("FAIL per edge=%0d observed=%b expected=%b", edge_n, per, exp_per);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press the button for n cycles starting at the next edge, then release
    task automatic press_hold(input int n);
        int s;
        s = edge_n + 1;
        btn_raw = 1'b1;
        iq.push_back(s + LAT);
`ifdef INIT_AUTOREPEAT_EN
        // Repeats continue while the raw level was still high LAT edges earlier
        for (int k = 1; REP * k < n; k++) iq.push_back(s + LAT + REP * k);
`endif
        ticks(n);
        btn_raw = 1'b0;
        ticks(12);
    endtask

    initial begin
        int s;
        clk      = 1'b0;
        checks   = 0;
        errors   = 0;
        edge_n   = 0;
        exp_per  = 1'b0;
        exp_init = 1'b0;

        // Reset held for three cycles with the button already pressed
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        sw_raw  = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        press_hold(20);

        // Clean press
        press_hold(20);

        // Bounce: 1,0,1,0 in 2-cycle segments, then steady high
        btn_raw = 1'b1; ticks(2);
        btn_raw = 1'b0; ticks(2);
        btn_raw = 1'b1; ticks(2);
        btn_raw = 1'b0; ticks(2);
        press_hold(20);

        // Short pulses on both inputs never reach the debounce threshold
        btn_raw = 1'b1; sw_raw = 1'b1; ticks(DEB - 1);
        btn_raw = 1'b0; sw_raw = 1'b0; ticks(12);

        // Switch rise with a 3-cycle glitch low: per rises once
        pq.push_back(edge_n + 1 + LAT);
        sw_raw = 1'b1; ticks(10);
        sw_raw = 1'b0; ticks(3);
        sw_raw = 1'b1; ticks(20);
        pq.push_back(edge_n + 1 + LAT);
        sw_raw = 1'b0; ticks(12);

        // Short release inside a press does not re-arm; a full release does
        s = edge_n + 1;
        iq.push_back(s + LAT);
`ifdef INIT_AUTOREPEAT_EN
        iq.push_back(s + LAT + REP);
`endif
        btn_raw = 1'b1; ticks(12);
        btn_raw = 1'b0; ticks(3);
        btn_raw = 1'b1; ticks(15);
        btn_raw = 1'b0; ticks(12);
        press_hold(10);

        // Simultaneous rise of both inputs
        sw_raw = 1'b1;
        pq.push_back(edge_n + 1 + LAT);
        press_hold(20);
        pq.push_back(edge_n + 1 + LAT);
        sw_raw = 1'b0; ticks(12);

        // Reset while HELD, button still pressed afterwards: fresh press
        s = edge_n + 1;
        iq.push_back(s + LAT);
        btn_raw = 1'b1; ticks(10);
        rst_n = 1'b0; ticks(2);
        rst_n = 1'b1;
        press_hold(20);

        // Reset in the middle of debouncing discards the partial count
        btn_raw = 1'b1; ticks(3);
        rst_n = 1'b0; ticks(2);
        rst_n = 1'b1;
        press_hold(20);

        // Long hold: repeat pulses at +16, +32, +48 when auto-repeat is built in
        press_hold(60);

        ticks(5);
        checks++;
        assert (iq.size() == 0) else begin
            errors++;
            $error("FAIL init_queue_drained observed=%0d expected=0", iq.size());
        end
        checks++;
        assert (pq.size() == 0) else begin
            errors++;
            $error("FAIL per_queue_drained observed=%0d expected=0", pq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
